ddr_sec_sched: RTL and testbench
================================

Name: ddr_sec_sched

Overview:
- Sequences and shares the single security/encryption datapath (mask + AES stage) between NUM_REQ requesters: write path, read path and scrub engine.
- Arbitrates one beat per cycle into a registered output stage and drives the datapath's stream input.
- Owns the active key and key_valid. Performs safe key rotation: stops new grants, drains outstanding beats, loads the new key, then resumes.
- Sits between the AXI/ECC front-end and the security datapath.

Parameters:
NUM_REQ, 3, number of requesters (≥2); index 0 = write, 1 = read, 2 = scrub
DATA_BYTES, 16, beat width in bytes (≥16)
MAX_OUTSTANDING, 4, maximum beats accepted but not yet completed (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester accept
req_data  in  NUM_REQ*DATA_BYTES*8  per-requester beat data, requester i at slice i
req_is_write  in  NUM_REQ  per-requester direction
sec_valid  out  1  beat valid to datapath
sec_ready  in  1  datapath accept
sec_data  out  DATA_BYTES*8  beat data
sec_is_write  out  1  beat direction
sec_src  out  $clog2(NUM_REQ)  requester id of the beat
cmp_valid  in  1  one downstream beat completed (pulse, one per beat)
key_upd_req  in  1  request key rotation (level; held until ack)
key_upd_key  in  128  new key, stable while key_upd_req is high
key_upd_ack  out  1  one-cycle pulse: new key is active
aes_key  out  128  active key
key_valid  out  1  active key loaded
outstanding  out  4  current outstanding count
err_underflow  out  1  sticky: cmp_valid received with outstanding == 0

Behaviour:
- Reset values: all outputs 0. FSM = NOKEY, round-robin pointer = 0, output register empty. Async assert, synchronous deassert use.
- FSM states:
  - NOKEY: no grants.
  - RUN: arbitrating.
  - DRAIN: no new grants; wait until output register is empty and outstanding == 0.
  - LOAD: one cycle.
- FSM transitions:
  - NOKEY → LOAD on key_upd_req.
  - RUN → DRAIN on key_upd_req.
  - DRAIN → LOAD when drain completes; same-cycle if already empty.
  - LOAD → RUN always.
- In LOAD: aes_key <= key_upd_key, key_valid <= 1, key_upd_ack pulses in the following cycle (first RUN cycle). key_upd_req must drop after ack; if still high on the second RUN cycle, a new rotation starts.
- Grant eligibility (grant possible in a cycle only when all hold):
  - state == RUN
  - outstanding < MAX_OUTSTANDING
  - output register empty, or sec_ready high this cycle
- Arbitration: round-robin among requesters with req_valid. Search starts at pointer. Pointer <= winner+1 (mod NUM_REQ) on each accepted beat only.
- Only the winner sees req_ready = 1. req_ready is combinational from req_valid/state/counters and never depends on the same requester's req_data.
- Latency: an accepted beat appears on sec_* the next cycle. Back-to-back beats sustain 1 beat/cycle when sec_ready is held high.
- Output hold: while sec_valid && !sec_ready, sec_data/sec_is_write/sec_src stay stable.
- outstanding counter:
  - +1 on req accept, −1 on cmp_valid; simultaneous accept and cmp_valid → unchanged.
  - At MAX_OUTSTANDING: no grant; a same-cycle cmp_valid does not enable a grant (counter value is used as registered).
  - cmp_valid at 0: counter stays 0 and err_underflow is set; cleared only by reset.
- key_upd_req during DRAIN or LOAD: no effect beyond the current rotation.
- Reset mid-beat or mid-drain: beat dropped, key cleared, return to NOKEY.

Optional Feature:
DDR_SEC_SCHED_WR_PRIO_EN
- Defined: requester 0 (write) has strict priority whenever req_valid[0] = 1. Remaining requesters use round-robin among themselves with their own pointer.
- Not defined: plain round-robin across all requesters as specified above.

Test Plan:
- Reset, then key_upd_req with key 0x0123..EF: LOAD in 1 cycle, aes_key = 0x0123..EF, key_valid = 1, key_upd_ack single pulse, no req_ready before then.
- All 3 requesters valid, sec_ready = 1, cmp_valid returned 2 cycles after each beat: sec_src sequence 0,1,2,0,1,2; throughput 1 beat/cycle.
- cmp_valid withheld: exactly 4 beats accepted, outstanding = 4, req_ready = 0. One cmp_valid pulse → next beat accepted the following cycle.
- sec_ready low for 5 cycles with a beat held: sec_data stable, no req_ready. Release → held beat transferred first.
- key_upd_req with 3 beats outstanding: no grants until 3 cmp_valid pulses received; new key applied, ack pulses, arbitration resumes from the saved pointer.
- cmp_valid pulse at outstanding = 0 → err_underflow = 1 and outstanding remains 0. With DDR_SEC_SCHED_WR_PRIO_EN defined and requesters 0 and 1 continuously valid → only requester 0 is granted.

Source files
------------

// File: rtl/ddr_sec_sched_if.sv
// Requester-side and datapath-side stream signals of the security scheduler.
// Master = front-end/datapath environment, slave = ddr_sec_sched.
interface ddr_sec_sched_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_BYTES = 16
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*DATA_BYTES*8-1:0] req_data;
    logic [NUM_REQ-1:0]              req_is_write;
    logic                            sec_valid;
    logic                            sec_ready;
    logic [DATA_BYTES*8-1:0]         sec_data;
    logic                            sec_is_write;
    logic [SRC_W-1:0]                sec_src;
    logic                            cmp_valid;

    modport master (
        output req_valid, req_data, req_is_write, sec_ready, cmp_valid,
        input  req_ready, sec_valid, sec_data, sec_is_write, sec_src
    );

    modport slave (
        input  req_valid, req_data, req_is_write, sec_ready, cmp_valid,
        output req_ready, sec_valid, sec_data, sec_is_write, sec_src
    );
endinterface

// File: rtl/ddr_sec_sched.sv
// Shares the mask+AES datapath between requesters and owns safe key rotation.
// Optional DDR_SEC_SCHED_WR_PRIO_EN: requester 0 gets strict priority over the rest.
module ddr_sec_sched #(
    parameter int NUM_REQ         = 3,
    parameter int DATA_BYTES      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ddr_sec_sched_if.slave bus,
    input  logic          key_upd_req,
    input  logic [127:0]  key_upd_key,
    output logic          key_upd_ack,
    output logic [127:0]  aes_key,
    output logic          key_valid,
    output logic [3:0]    outstanding,
    output logic          err_underflow
);
    localparam int          DW    = DATA_BYTES * 8;
    localparam int          SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR    = NUM_REQ;

    typedef enum logic [1:0] {NOKEY, RUN, DRAIN, LOAD} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] win, idx;
    logic             win_found, grant_ok, accept, drained;
    logic [DW-1:0]    win_data;
    logic             win_wr;
`ifdef DDR_SEC_SCHED_WR_PRIO_EN
    logic [SRC_W-1:0] lo_ptr;
`else
    logic [SRC_W-1:0] rr_ptr;
`endif

    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
`ifdef DDR_SEC_SCHED_WR_PRIO_EN
        if (bus.req_valid[0]) begin
            win_found = 1'b1;
        end else begin
            // lo_ptr ranges over 1..NR-1; requester 0 never takes part here
            for (int unsigned i = 0; i < NR - 1; i++) begin
                idx = SRC_W'(1 + (32'(lo_ptr) - 1 + i) % (NR - 1));
                if (!win_found && bus.req_valid[idx]) begin
                    win_found = 1'b1;
                    win       = idx;
                end
            end
        end
`else
        for (int unsigned i = 0; i < NR; i++) begin
            idx = SRC_W'((32'(rr_ptr) + i) % NR);
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
`endif
    end

    always_comb begin
        win_data = '0;
        win_wr   = 1'b0;
        for (int unsigned j = 0; j < NR; j++) begin
            if (win == SRC_W'(j)) begin
                win_data = bus.req_data[j*DW +: DW];
                win_wr   = bus.req_is_write[j];
            end
        end
    end

    // Registered count only: a same-cycle completion cannot open a slot
    assign grant_ok = (state == RUN) && (outstanding < 4'(MAX_OUTSTANDING)) &&
                      (!bus.sec_valid || bus.sec_ready);
    assign accept   = grant_ok && win_found;
    assign drained  = !bus.sec_valid && (outstanding == '0);

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready = NUM_REQ'(1) << win;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NOKEY: if (key_upd_req) state_nxt = LOAD;
            // The ack cycle is ignored so a requester still holding req can drop it
            RUN:   if (key_upd_req && !key_upd_ack) state_nxt = DRAIN;
            DRAIN: if (drained) state_nxt = LOAD;
            LOAD:  state_nxt = RUN;
            default: state_nxt = NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= NOKEY;
`ifdef DDR_SEC_SCHED_WR_PRIO_EN
            lo_ptr           <= SRC_W'(1);
`else
            rr_ptr           <= '0;
`endif
            bus.sec_valid    <= 1'b0;
            bus.sec_data     <= '0;
            bus.sec_is_write <= 1'b0;
            bus.sec_src      <= '0;
            key_upd_ack      <= 1'b0;
            aes_key          <= '0;
            key_valid        <= 1'b0;
            outstanding      <= '0;
            err_underflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_upd_ack <= (state == LOAD);
            if (state == LOAD) begin
                aes_key   <= key_upd_key;
                key_valid <= 1'b1;
            end

            if (accept) begin
                bus.sec_valid    <= 1'b1;
                bus.sec_data     <= win_data;
                bus.sec_is_write <= win_wr;
                bus.sec_src      <= win;
`ifdef DDR_SEC_SCHED_WR_PRIO_EN
                if (win != '0) begin
                    lo_ptr <= (win == SRC_W'(NR - 1)) ? SRC_W'(1) : win + 1'b1;
                end
`else
                rr_ptr <= (win == SRC_W'(NR - 1)) ? '0 : win + 1'b1;
`endif
            end else if (bus.sec_ready) begin
                bus.sec_valid <= 1'b0;
            end

            if (bus.cmp_valid && (outstanding == '0)) begin
                err_underflow <= 1'b1;
            end
            if (accept && !bus.cmp_valid) begin
                outstanding <= outstanding + 4'd1;
            end else if (!accept && bus.cmp_valid && (outstanding != '0)) begin
                outstanding <= outstanding - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ddr_sec_sched.sv
// Directed bench for ddr_sec_sched: reset, key load, arbitration, limits, backpressure, rotation.
module tb_ddr_sec_sched;
    localparam int NR = 3;
    localparam int DB = 16;
    localparam logic [127:0] KEY1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] KEY2 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    logic         clk;
    logic         rst_n;
    logic         key_upd_req;
    logic [127:0] key_upd_key;
    logic         key_upd_ack;
    logic [127:0] aes_key;
    logic         key_valid;
    logic [3:0]   outstanding;
    logic         err_underflow;

    int vectors    = 0;
    int miscompares = 0;
    logic [127:0] dat [NR];

    ddr_sec_sched_if #(.NUM_REQ(NR), .DATA_BYTES(DB)) bus ();

    ddr_sec_sched #(.NUM_REQ(NR), .DATA_BYTES(DB), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .key_upd_req(key_upd_req), .key_upd_key(key_upd_key), .key_upd_ack(key_upd_ack),
        .aes_key(aes_key), .key_valid(key_valid), .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.sec_ready = 1'b1;
        bus.cmp_valid = 1'b0;
        key_upd_req   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.sec_valid !== 1'b0 || bus.req_ready !== 3'b000 || key_upd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stream: sec_valid=%b req_ready=%b ack=%b, required 0 000 0",
                     bus.sec_valid, bus.req_ready, key_upd_ack);
        end
        vectors++;
        if (key_valid !== 1'b0 || aes_key !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_key: key_valid=%b aes_key=%h, required 0 0", key_valid, aes_key);
        end
        vectors++;
        if (outstanding !== 4'd0 || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_count: outstanding=%0d err=%b, required 0 0", outstanding, err_underflow);
        end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_key_load();
        bus.req_valid = '1;
        key_upd_key   = KEY1;
        key_upd_req   = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL key_nokey_ready: req_ready=%b, required 000", bus.req_ready);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 3'b000 || key_upd_ack !== 1'b0 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL key_load_cycle: req_ready=%b ack=%b key_valid=%b, required 000 0 0",
                     bus.req_ready, key_upd_ack, key_valid);
        end
        next_cycle();
        bus.req_valid = '0;
        key_upd_req   = 1'b0;
        @(negedge clk);
        vectors++;
        if (key_upd_ack !== 1'b1 || key_valid !== 1'b1 || aes_key !== KEY1) begin
            miscompares++;
            $display("FAIL key_applied: ack=%b key_valid=%b aes_key=%h, required 1 1 %h",
                     key_upd_ack, key_valid, aes_key, KEY1);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (key_upd_ack !== 1'b0 || key_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL key_ack_pulse: ack=%b key_valid=%b, required 0 1", key_upd_ack, key_valid);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy;
        int k;
        int exp_out;
        bus.sec_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = (c < 6) ? 3'b111 : 3'b000;
            bus.cmp_valid = (c >= 2);
            @(negedge clk);
            if (c < 6) begin
                exp_rdy = 3'(1 << (c % 3));
                vectors++;
                if (bus.req_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL rr_grant c=%0d: req_ready=%b, required %b", c, bus.req_ready, exp_rdy);
                end
            end
            if (c >= 1 && c <= 6) begin
                k = (c - 1) % 3;
                vectors++;
                if (bus.sec_valid !== 1'b1 || bus.sec_src !== 2'(k) || bus.sec_data !== dat[k] ||
                    bus.sec_is_write !== (k == 0)) begin
                    miscompares++;
                    $display("FAIL rr_beat c=%0d: valid=%b src=%0d wr=%b data=%h, required 1 %0d %b %h",
                             c, bus.sec_valid, bus.sec_src, bus.sec_is_write, bus.sec_data, k, (k == 0), dat[k]);
                end
            end
            if (c == 7) begin
                vectors++;
                if (bus.sec_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rr_empty: sec_valid=%b, required 0", bus.sec_valid);
                end
            end
            exp_out = (c == 0) ? 0 : (c == 1) ? 1 : (c <= 6) ? 2 : 1;
            vectors++;
            if (outstanding !== 4'(exp_out)) begin
                miscompares++;
                $display("FAIL rr_outstanding c=%0d: outstanding=%0d, required %0d", c, outstanding, exp_out);
            end
            next_cycle();
        end
        bus.cmp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL rr_final_count: outstanding=%0d, required 0", outstanding);
        end
        next_cycle();
    endtask

    task automatic test_outstanding_limit();
        int accepted = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 3'b111;
            bus.cmp_valid = (c == 6);
            @(negedge clk);
            if (bus.req_ready !== 3'b000) accepted++;
            if (c >= 4 && c <= 6) begin
                vectors++;
                if (bus.req_ready !== 3'b000 || outstanding !== 4'd4) begin
                    miscompares++;
                    $display("FAIL lim_block c=%0d: req_ready=%b outstanding=%0d, required 000 4",
                             c, bus.req_ready, outstanding);
                end
            end
            if (c == 6) begin
                vectors++;
                if (accepted !== 4) begin
                    miscompares++;
                    $display("FAIL lim_accepted: beats=%0d, required 4", accepted);
                end
            end
            if (c == 7) begin
                vectors++;
                if (bus.req_ready !== 3'b010 || outstanding !== 4'd3) begin
                    miscompares++;
                    $display("FAIL lim_resume: req_ready=%b outstanding=%0d, required 010 3",
                             bus.req_ready, outstanding);
                end
            end
            next_cycle();
        end
        bus.req_valid = '0;
        bus.cmp_valid = 1'b1;
        repeat (4) next_cycle();
        bus.cmp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 4'd0 || bus.sec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lim_drain: outstanding=%0d sec_valid=%b, required 0 0", outstanding, bus.sec_valid);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c <= 6) ? 3'b111 : 3'b000;
            bus.sec_ready = (c >= 6);
            bus.cmp_valid = (c >= 8);
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if (bus.req_ready !== 3'b100) begin
                    miscompares++;
                    $display("FAIL bp_first: req_ready=%b, required 100", bus.req_ready);
                end
            end
            if (c >= 1 && c <= 5) begin
                vectors++;
                if (bus.req_ready !== 3'b000 || bus.sec_valid !== 1'b1 || bus.sec_src !== 2'd2 ||
                    bus.sec_data !== dat[2]) begin
                    miscompares++;
                    $display("FAIL bp_hold c=%0d: req_ready=%b valid=%b src=%0d data=%h, required 000 1 2 %h",
                             c, bus.req_ready, bus.sec_valid, bus.sec_src, bus.sec_data, dat[2]);
                end
            end
            if (c == 6) begin
                vectors++;
                if (bus.req_ready !== 3'b001 || bus.sec_valid !== 1'b1 || bus.sec_src !== 2'd2) begin
                    miscompares++;
                    $display("FAIL bp_release: req_ready=%b valid=%b src=%0d, required 001 1 2",
                             bus.req_ready, bus.sec_valid, bus.sec_src);
                end
            end
            if (c == 7) begin
                vectors++;
                if (bus.sec_valid !== 1'b1 || bus.sec_src !== 2'd0 || bus.sec_data !== dat[0]) begin
                    miscompares++;
                    $display("FAIL bp_next: valid=%b src=%0d data=%h, required 1 0 %h",
                             bus.sec_valid, bus.sec_src, bus.sec_data, dat[0]);
                end
            end
            if (c == 8) begin
                vectors++;
                if (bus.sec_valid !== 1'b0 || outstanding !== 4'd2) begin
                    miscompares++;
                    $display("FAIL bp_empty: valid=%b outstanding=%0d, required 0 2", bus.sec_valid, outstanding);
                end
            end
            next_cycle();
        end
        bus.cmp_valid = 1'b0;
    endtask

    task automatic test_key_rotation();
        logic [2:0] exp_rdy;
        bit seen = 0;
        key_upd_key   = KEY2;
        bus.sec_ready = 1'b1;
        bus.cmp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = 3'b111;
            @(negedge clk);
            exp_rdy = 3'(1 << ((1 + c) % 3));
            vectors++;
            if (bus.req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rot_prefill c=%0d: req_ready=%b, required %b", c, bus.req_ready, exp_rdy);
            end
            next_cycle();
        end
        bus.req_valid = 3'b000;
        key_upd_req   = 1'b1;
        @(negedge clk);
        vectors++;
        if (outstanding !== 4'd3) begin
            miscompares++;
            $display("FAIL rot_outstanding: outstanding=%0d, required 3", outstanding);
        end
        next_cycle();
        bus.req_valid = 3'b111;
        for (int n = 0; n < 12 && !seen; n++) begin
            bus.cmp_valid = (n >= 2 && n <= 4);
            @(negedge clk);
            if (key_upd_ack === 1'b1) begin
                seen = 1;
                vectors++;
                if (aes_key !== KEY2 || outstanding !== 4'd0 || bus.req_ready !== 3'b010) begin
                    miscompares++;
                    $display("FAIL rot_resume: aes_key=%h outstanding=%0d req_ready=%b, required %h 0 010",
                             aes_key, outstanding, bus.req_ready, KEY2);
                end
            end else begin
                vectors++;
                if (bus.req_ready !== 3'b000 || aes_key !== KEY1) begin
                    miscompares++;
                    $display("FAIL rot_blocked n=%0d: req_ready=%b aes_key=%h, required 000 %h",
                             n, bus.req_ready, aes_key, KEY1);
                end
            end
            next_cycle();
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL rot_ack_timeout: ack=0 after 12 cycles, required 1");
        end
        key_upd_req   = 1'b0;
        bus.cmp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (key_upd_ack !== 1'b0 || bus.req_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL rot_after: ack=%b req_ready=%b, required 0 100", key_upd_ack, bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 3'b000;
        bus.cmp_valid = 1'b1;
        repeat (2) next_cycle();
        bus.cmp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 4'd0 || bus.sec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rot_drain: outstanding=%0d sec_valid=%b, required 0 0", outstanding, bus.sec_valid);
        end
        next_cycle();
    endtask

    task automatic test_wr_prio();
        logic [2:0] exp_rdy;
        for (int c = 0; c < 6; c++) begin
            bus.req_valid = (c < 4) ? 3'b011 : 3'b000;
            bus.cmp_valid = (c >= 2);
            @(negedge clk);
            if (c < 4) begin
`ifdef DDR_SEC_SCHED_WR_PRIO_EN
                exp_rdy = 3'b001;
`else
                exp_rdy = (c % 2 == 0) ? 3'b001 : 3'b010;
`endif
                vectors++;
                if (bus.req_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL prio_grant c=%0d: req_ready=%b, required %b", c, bus.req_ready, exp_rdy);
                end
            end
            next_cycle();
        end
        bus.cmp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL prio_drain: outstanding=%0d, required 0", outstanding);
        end
        next_cycle();
    endtask

    task automatic test_underflow();
        bus.req_valid = 3'b000;
        bus.cmp_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_before: err=%b, required 0", err_underflow);
        end
        next_cycle();
        bus.cmp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (err_underflow !== 1'b1 || outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL uf_set: err=%b outstanding=%0d, required 1 0", err_underflow, outstanding);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (err_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_sticky: err=%b, required 1", err_underflow);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 3'b001;
        bus.sec_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL rm_grant: req_ready=%b, required 001", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.sec_valid !== 1'b0 || key_valid !== 1'b0 || aes_key !== 128'h0 ||
            outstanding !== 4'd0 || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_async: valid=%b key_valid=%b key=%h outstanding=%0d err=%b, required 0 0 0 0 0",
                     bus.sec_valid, key_valid, aes_key, outstanding, err_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        bus.req_valid = 3'b111;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL rm_nokey: req_ready=%b, required 000", bus.req_ready);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) dat[i] = {4{32'hDA7A_0000 | 32'(i)}};
        bus.req_data     = {dat[2], dat[1], dat[0]};
        bus.req_is_write = 3'b001;
        bus.req_valid    = '0;
        bus.sec_ready    = 1'b0;
        bus.cmp_valid    = 1'b0;
        key_upd_req      = 1'b0;
        key_upd_key      = '0;
        rst_n            = 1'b0;

        test_reset();
        test_key_load();
        test_round_robin();
        test_outstanding_limit();
        test_backpressure();
        test_key_rotation();
        test_wr_prio();
        test_underflow();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
